fifo_write_arbiter: RTL and testbench

Round-robin write arbiter that lets several 8-bit producers share the write port of one FIFO. Each requester holds a request, receives a one-hot grant, and streams bytes in bursts of at most BURST_LEN beats before the grant rotates. The block drives the FIFO's data input and write enable and respects its full flag. It sits between the producer blocks and the FIFO instance.

---
 rtl/fifo_write_arbiter.sv | 146 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin write arbiter: several byte producers share one FIFO write port,
// each owner streams up to BURST_LEN beats before the grant rotates.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | no owner; gnt/fifoWe/ack/busy low, fifoDataIn forced to 0
//   S_GRANT | owner_q holds the grant and writes while its req is high
//           | and the FIFO is not full
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     ack,
    output logic [7:0]             fifoDataIn,
    output logic                   fifoWe,
    input  logic                   fifoFull,
    output logic                   busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   beats_q, beats_d;

    logic [NUM_REQ-1:0] owner_oh;
    logic [7:0]         sel_data;
    logic               owner_req;
    logic               we;
    logic               rotate;
    logic [BW-1:0]      beats_inc;
    logic [IW-1:0]      search_base;
    logic [IW:0]        srch;

    // Returns {found, winner}: first requester at or after base, wrapping.
    function automatic logic [IW:0] search(input logic [NUM_REQ-1:0] r,
                                           input logic [IW-1:0]      base);
        logic          found;
        logic [IW-1:0] win;
        logic [IW-1:0] idx;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IW'((int'(base) + i) % NUM_REQ);
            if (!found && r[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] o);
        return (o == IW'(NUM_REQ - 1)) ? '0 : o + IW'(1);
    endfunction

    always_comb begin
        owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
        owner_req = req[owner_q];
        sel_data = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IW'(k)) begin
                sel_data = data[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        beats_d   = beats_q;
        gnt       = '0;
        ack       = '0;
        fifoWe    = 1'b0;
        fifoDataIn = 8'h00;
        busy      = 1'b0;

        we        = (state_q == S_GRANT) && owner_req && !fifoFull;
        beats_inc = beats_q + BW'(1);
        rotate    = 1'b0;
        // From IDLE the search starts at ptr; on rotation it starts past the owner.
        search_base = (state_q == S_IDLE) ? ptr_q : next_idx(owner_q);
        srch      = search(req, search_base);

        case (state_q)
            S_IDLE: begin
                if (srch[IW]) begin
                    state_d = S_GRANT;
                    owner_d = srch[IW-1:0];
                    beats_d = '0;
                end
            end
            S_GRANT: begin
                gnt        = owner_oh;
                busy       = 1'b1;
                fifoWe     = we;
                ack        = we ? owner_oh : '0;
                fifoDataIn = sel_data;
                rotate     = !owner_req || (we && (beats_inc == BW'(BURST_LEN)));
                if (we) begin
                    beats_d = beats_inc;
                end
                if (rotate) begin
                    ptr_d   = search_base;
                    beats_d = '0;
                    if (srch[IW]) begin
                        owner_d = srch[IW-1:0];
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            beats_q <= beats_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: a vector table for a single-requester
// stream plus hand-written sequences for reset, full stalls, handoffs and drops.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  fifoDataIn;
    logic        fifoWe;
    logic        fifoFull;
    logic        busy;

    int total;
    int bad;

    fifo_write_arbiter #(.NUM_REQ(4), .BURST_LEN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data       (data),
        .gnt        (gnt),
        .ack        (ack),
        .fifoDataIn (fifoDataIn),
        .fifoWe     (fifoWe),
        .fifoFull   (fifoFull),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [7:0]  byte1;
        logic        full;
        logic [3:0]  exp_gnt;
        logic        exp_we;
        logic [7:0]  exp_din;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the outputs of one GRANT/IDLE cycle; din only when it is defined.
    task automatic chk_cycle(input string name, input logic [3:0] eg, input logic ewe,
                             input logic [7:0] ed, input logic eb);
        chk({name, ".gnt"}, 32'(gnt), 32'(eg));
        chk({name, ".we"}, 32'(fifoWe), 32'(ewe));
        chk({name, ".ack"}, 32'(ack), ewe ? 32'(eg) : 32'd0);
        chk({name, ".busy"}, 32'(busy), 32'(eb));
        if (ewe || !eb) chk({name, ".din"}, 32'(fifoDataIn), 32'(ed));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] eg;
        total = 0;
        bad = 0;

        // req[1] streams 0x10..0x15 starting from IDLE (ptr=3 at this point)
        vecs[0] = '{4'b0010, 8'h10, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};
        vecs[1] = '{4'b0010, 8'h10, 1'b0, 4'b0010, 1'b1, 8'h10, 1'b1};
        vecs[2] = '{4'b0010, 8'h11, 1'b0, 4'b0010, 1'b1, 8'h11, 1'b1};
        vecs[3] = '{4'b0010, 8'h12, 1'b0, 4'b0010, 1'b1, 8'h12, 1'b1};
        vecs[4] = '{4'b0010, 8'h13, 1'b0, 4'b0010, 1'b1, 8'h13, 1'b1};
        vecs[5] = '{4'b0010, 8'h14, 1'b0, 4'b0010, 1'b1, 8'h14, 1'b1};
        vecs[6] = '{4'b0010, 8'h15, 1'b0, 4'b0010, 1'b1, 8'h15, 1'b1};
        vecs[7] = '{4'b0000, 8'h15, 1'b0, 4'b0010, 1'b0, 8'h00, 1'b1};
        vecs[8] = '{4'b0000, 8'h15, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0};

        reset = 1'b0;
        req = 4'b0000;
        fifoFull = 1'b0;
        data = 32'hA3A2A1A0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            tick();
            req = 4'($urandom_range(0, 15));
            fifoFull = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_cycle("rst_hold", 4'b0000, 1'b0, 8'h00, 1'b0);
        end

        // Release with req=0100
        tick();
        req = 4'b0100;
        fifoFull = 1'b0;
        #2 reset = 1'b1;
        tick();
        @(negedge clk);
        chk_cycle("rst_rel", 4'b0100, 1'b1, 8'hA2, 1'b1);
        tick();
        req = 4'b0000;
        @(negedge clk);
        chk_cycle("rel_drop", 4'b0100, 1'b0, 8'h00, 1'b1);
        tick();
        @(negedge clk);
        chk_cycle("rel_idle", 4'b0000, 1'b0, 8'h00, 1'b0);
        tick();

        // Single requester table
        for (int i = 0; i < 9; i++) begin
            req = vecs[i].req;
            data[15:8] = vecs[i].byte1;
            fifoFull = vecs[i].full;
            @(negedge clk);
            chk_cycle($sformatf("single[%0d]", i), vecs[i].exp_gnt, vecs[i].exp_we,
                      vecs[i].exp_din, vecs[i].exp_busy);
            tick();
        end

        // Reset asserted mid-burst between edges
        data = 32'hA3A2A1A0;
        req = 4'b1111;
        tick();
        #2 reset = 1'b0;
        #1;
        chk_cycle("rst_mid", 4'b0000, 1'b0, 8'h00, 1'b0);
        tick();
        chk_cycle("rst_mid_hold", 4'b0000, 1'b0, 8'h00, 1'b0);
        #2 reset = 1'b1;
        tick();

        // All four requesting: order 0,1,2,3,0 with 4 writes each, no gaps
        for (int k = 0; k < 20; k++) begin
            eg = 4'b0001 << ((k / 4) % 4);
            @(negedge clk);
            chk_cycle($sformatf("rr[%0d]", k), eg, 1'b1, 8'hA0 + 8'((k / 4) % 4), 1'b1);
            tick();
        end

        // FIFO full stall inside requester 2's burst
        req = 4'b0100;
        data[23:16] = 8'hC0;
        @(negedge clk);
        chk_cycle("full_rot", 4'b0010, 1'b0, 8'h00, 1'b1);
        tick();
        @(negedge clk);
        chk_cycle("full_b1", 4'b0100, 1'b1, 8'hC0, 1'b1);
        tick();
        data[23:16] = 8'hC1;
        @(negedge clk);
        chk_cycle("full_b2", 4'b0100, 1'b1, 8'hC1, 1'b1);
        tick();
        fifoFull = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_cycle($sformatf("full_stall[%0d]", i), 4'b0100, 1'b0, 8'h00, 1'b1);
            tick();
        end
        fifoFull = 1'b0;
        req = 4'b1100;
        data[23:16] = 8'hC2;
        data[31:24] = 8'hB3;
        @(negedge clk);
        chk_cycle("full_b3", 4'b0100, 1'b1, 8'hC2, 1'b1);
        tick();
        data[23:16] = 8'hC3;
        @(negedge clk);
        chk_cycle("full_b4", 4'b0100, 1'b1, 8'hC3, 1'b1);
        tick();
        req = 4'b0000;
        @(negedge clk);
        chk_cycle("full_next", 4'b1000, 1'b0, 8'h00, 1'b1);
        tick();

        // Requester 0 drops after 2 beats while requester 3 is pending
        req = 4'b1001;
        data = 32'hE0_00_00_D0;
        @(negedge clk);
        chk_cycle("drop_idle", 4'b0000, 1'b0, 8'h00, 1'b0);
        tick();
        @(negedge clk);
        chk_cycle("drop_b1", 4'b0001, 1'b1, 8'hD0, 1'b1);
        tick();
        data[7:0] = 8'hD1;
        @(negedge clk);
        chk_cycle("drop_b2", 4'b0001, 1'b1, 8'hD1, 1'b1);
        tick();
        req = 4'b1000;
        @(negedge clk);
        chk_cycle("drop_rel", 4'b0001, 1'b0, 8'h00, 1'b1);
        tick();
        chk("drop_ptr", 32'(dut.ptr_q), 32'd1);
        for (int i = 0; i < 4; i++) begin
            data[31:24] = 8'hE0 + 8'(i);
            @(negedge clk);
            chk_cycle($sformatf("drop_r3[%0d]", i), 4'b1000, 1'b1, 8'hE0 + 8'(i), 1'b1);
            tick();
        end
        req = 4'b0000;
        @(negedge clk);
        chk_cycle("drop_end", 4'b1000, 1'b0, 8'h00, 1'b1);
        tick();
        @(negedge clk);
        chk_cycle("final_idle", 4'b0000, 1'b0, 8'h00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
